itrx_aib_phy_repair_ld: RTL and testbench



---
 rtl/itrx_aib_phy_repair_ld.sv | 199 +++++++++++++++++++
 tb/tb_itrx_aib_phy_repair_ld.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itrx_aib_phy_repair_ld.sv
// itrx_aib_phy_repair_ld
// Serial loader for per-channel AIB repair records. It reads MAXCH records,
// channel 0 first, from a fuse/NVM shift interface into a shadow copy, then
// presents all channels on repair_info_nvm/repair_info_vld in one cycle so
// the downstream repair encoder never sees a partial load.
// Record (MSB first): vld, info[10:0] [, odd parity over the 12 record bits].
// Optional feature macro: ITRX_AIB_REPAIR_PARITY_EN (adds the parity bit,
// invalidates bad records and drives the sticky load_err flag).
module itrx_aib_phy_repair_ld #(
  parameter int unsigned MAXCH  = 32'd1,
  parameter int unsigned CLKDIV = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  output logic                   nvm_cs_n,
  output logic                   nvm_sclk,
  input  logic                   nvm_sdata,
  output logic [MAXCH-1:0][10:0] repair_info_nvm,
  output logic [MAXCH-1:0]       repair_info_vld,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err
);

`ifdef ITRX_AIB_REPAIR_PARITY_EN
  localparam int unsigned RECW = 13;
`else
  localparam int unsigned RECW = 12;
`endif
  localparam int unsigned CHW  = (MAXCH > 1) ? $clog2(MAXCH) : 1;
  localparam int unsigned BITW = $clog2(RECW);

  localparam logic [CHW-1:0]  LAST_CH  = CHW'(MAXCH - 1);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(RECW - 1);
  localparam logic [7:0]      DIV_LAST = 8'(CLKDIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]      div_cnt;
  logic [BITW-1:0] bit_cnt;
  logic [CHW-1:0]  ch_cnt;
  logic            sclk_q;
  logic [RECW-2:0] rec_sr;

  logic [MAXCH-1:0][10:0] shadow_info;
  logic [MAXCH-1:0]       shadow_vld;

  logic            phase_end;
  logic            start_ok;
  logic            sample_en;
  logic            fall_en;
  logic            rec_last;
  logic            load_last;
  logic [RECW-1:0] rec_full;
  logic            rec_vld;
  logic [10:0]     rec_info;
  logic            rec_ok;

  // Decode the divider phase and the bit/record/load boundaries.
  always_comb begin
    phase_end = (div_cnt == DIV_LAST);
    start_ok  = (state == IDLE) && load_start;
    sample_en = (state == SHIFT) && phase_end && !sclk_q;
    fall_en   = (state == SHIFT) && phase_end && sclk_q;
    rec_last  = (bit_cnt == LAST_BIT);
    load_last = rec_last && (ch_cnt == LAST_CH);
    rec_full  = {rec_sr, nvm_sdata};
    rec_vld   = rec_full[RECW-1];
    rec_info  = rec_full[RECW-2 -: 11];
`ifdef ITRX_AIB_REPAIR_PARITY_EN
    rec_ok    = ^rec_full;
`else
    rec_ok    = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:    if (load_start)           state_nxt = SETUP;
      SETUP:   if (phase_end)            state_nxt = SHIFT;
      SHIFT:   if (fall_en && load_last) state_nxt = LATCH;
      LATCH:                             state_nxt = DONE;
      DONE:                              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Interface outputs: chip select spans SETUP and SHIFT only.
  always_comb begin
    nvm_cs_n = !((state == SETUP) || (state == SHIFT));
    nvm_sclk = sclk_q;
  end

  // Shift-clock divider, sclk phase and bit/channel counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      ch_cnt  <= '0;
    end else begin
      if ((state == SETUP) || (state == SHIFT))
        div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;
      else
        div_cnt <= 8'd0;

      if (sample_en)    sclk_q <= 1'b1;
      else if (fall_en) sclk_q <= 1'b0;

      if (start_ok) begin
        bit_cnt <= '0;
        ch_cnt  <= '0;
      end else if (fall_en) begin
        if (rec_last) begin
          bit_cnt <= '0;
          // Wrap to 0 after the final channel so the count never passes MAXCH-1.
          ch_cnt  <= load_last ? '0 : ch_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Capture serial data and commit each complete record to the shadow copy.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow store is reset on purpose: a reset mid-load must not
    // leave a stale record that a later partial load could expose.
    if (!rst_n) begin
      rec_sr      <= '0;
      shadow_info <= '0;
      shadow_vld  <= '0;
    end else if (sample_en) begin
      rec_sr <= {rec_sr[RECW-3:0], nvm_sdata};
      if (rec_last) begin
        shadow_vld[ch_cnt]  <= rec_ok & rec_vld;
        shadow_info[ch_cnt] <= rec_ok ? rec_info : 11'd0;
      end
    end
  end

  // Publish every channel together in the LATCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repair_info_nvm <= '0;
      repair_info_vld <= '0;
    end else if (state == LATCH) begin
      repair_info_nvm <= shadow_info;
      repair_info_vld <= shadow_vld;
    end
  end

  // Load handshake flags: busy from acceptance to LATCH, done sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_busy <= 1'b0;
      load_done <= 1'b0;
    end else begin
      if (start_ok)             load_busy <= 1'b1;
      else if (state == LATCH)  load_busy <= 1'b0;

      if (start_ok)             load_done <= 1'b0;
      else if (state == DONE)   load_done <= 1'b1;
    end
  end

`ifdef ITRX_AIB_REPAIR_PARITY_EN
  // Sticky parity error, cleared by the next accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              load_err <= 1'b0;
    else if (start_ok)                       load_err <= 1'b0;
    else if (sample_en && rec_last && !rec_ok) load_err <= 1'b1;
  end
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_itrx_aib_phy_repair_ld.sv
// Testbench for itrx_aib_phy_repair_ld (MAXCH=3, CLKDIV=2).
// A simple NVM device model serves the record stream; a timing model derived
// from the load-duration formula predicts every output on every cycle.
`timescale 1ns/1ps
module tb_itrx_aib_phy_repair_ld;

  localparam int MAXCH  = 3;
  localparam int CLKDIV = 2;
`ifdef ITRX_AIB_REPAIR_PARITY_EN
  localparam int RECW   = 13;
  localparam int LAT_LIT = 160;  // 2*(2*39+1)+2
`else
  localparam int RECW   = 12;
  localparam int LAT_LIT = 148;  // 2*(2*36+1)+2
`endif
  localparam int N = MAXCH * RECW;
  localparam int X = CLKDIV * (2 * N + 1);

  typedef struct packed {
    logic        vld;
    logic [10:0] info;
    logic        bad;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_start = 1'b0;
  logic nvm_cs_n, nvm_sclk, nvm_sdata;
  logic [MAXCH-1:0][10:0] repair_info_nvm;
  logic [MAXCH-1:0]       repair_info_vld;
  logic load_busy, load_done, load_err;

  itrx_aib_phy_repair_ld #(.MAXCH(MAXCH), .CLKDIV(CLKDIV)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_start      (load_start),
    .nvm_cs_n        (nvm_cs_n),
    .nvm_sclk        (nvm_sclk),
    .nvm_sdata       (nvm_sdata),
    .repair_info_nvm (repair_info_nvm),
    .repair_info_vld (repair_info_vld),
    .load_busy       (load_busy),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- NVM device model ----------------
  logic stream [0:63];
  int   rise_cnt = 0;
  int   total_rises = 0;
  logic dev_bit = 1'b0;
  logic noise_en = 1'b0;
  logic noise = 1'b0;

  assign nvm_sdata = noise_en ? noise : dev_bit;

  always @(posedge nvm_sclk) total_rises++;

  always @(posedge nvm_sclk or posedge nvm_cs_n) begin
    if (nvm_cs_n) rise_cnt = 0;
    else          rise_cnt++;
  end

  // Device presents the next bit on sclk falling edge (bit 0 on select).
  always @(negedge nvm_sclk or negedge nvm_cs_n)
    dev_bit = (rise_cnt < 64) ? stream[rise_cnt] : 1'b0;

  // ---------------- behavioural model ----------------
  logic [MAXCH-1:0][10:0] pend_info, new_info, cur_info;
  logic [MAXCH-1:0]       pend_vld, new_vld, cur_vld;
  logic pend_err, new_err;
  int   cyc, t0;
  logic have_load;
  logic chk_en = 1'b0;

  // Accept a start only when no load is active and the DONE cycle is past.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; t0 = 0; have_load = 1'b0;
      cur_info = '0; cur_vld = '0; new_info = '0; new_vld = '0; new_err = 1'b0;
    end else begin
      cyc++;
      if (load_start && (!have_load || (cyc - t0) >= X + 3)) begin
        if (have_load) begin
          cur_info = new_info;
          cur_vld  = new_vld;
        end
        new_info = pend_info; new_vld = pend_vld; new_err = pend_err;
        t0 = cyc; have_load = 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    int   k;
    logic e_csn, e_sclk, e_busy, e_done, active;
    logic [MAXCH-1:0][10:0] e_info;
    logic [MAXCH-1:0]       e_vld;
    if (chk_en) begin
      k      = cyc - t0;
      e_csn  = !(have_load && k <= X - 1);
      e_sclk = have_load && k >= CLKDIV && k <= X - 1 &&
               ((k - CLKDIV) % (2 * CLKDIV)) >= CLKDIV;
      e_busy = have_load && k <= X;
      e_done = have_load && k >= X + 2;
      active = have_load && k <= X;
      e_info = (have_load && k >= X + 1) ? new_info : cur_info;
      e_vld  = (have_load && k >= X + 1) ? new_vld  : cur_vld;
      check("cs_n", nvm_cs_n, e_csn);
      check("sclk", nvm_sclk, e_sclk);
      check("busy", load_busy, e_busy);
      check("done", load_done, e_done);
      check("info", repair_info_nvm, e_info);
      check("vld", repair_info_vld, e_vld);
      if (!active) check("err", load_err, have_load & new_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_load(input rec_t r0, input rec_t r1, input rec_t r2);
    rec_t r [3];
    int p;
    logic [RECW-1:0] bits;
    logic par;
    r[0] = r0; r[1] = r1; r[2] = r2;
    p = 0;
    pend_err = 1'b0;
    for (int c = 0; c < MAXCH; c++) begin
      par = ~^{r[c].vld, r[c].info};
`ifdef ITRX_AIB_REPAIR_PARITY_EN
      bits = {r[c].vld, r[c].info, par ^ r[c].bad};
      pend_vld[c]  = r[c].bad ? 1'b0 : r[c].vld;
      pend_info[c] = r[c].bad ? 11'd0 : r[c].info;
      if (r[c].bad) pend_err = 1'b1;
`else
      bits = {r[c].vld, r[c].info};
      pend_vld[c]  = r[c].vld;
      pend_info[c] = r[c].info;
`endif
      for (int b = RECW - 1; b >= 0; b--) begin
        stream[p] = bits[b];
        p++;
      end
    end
  endtask

  task automatic run_load(input string name, input bit poke_busy, input bit poke_done);
    int lat;
    int r0;
    bit seen;
    r0 = total_rises;
    seen = 1'b0;
    @(negedge clk) load_start = 1'b1;
    @(posedge clk) #1 load_start = 1'b0;
    check({name, "_done_clear"}, load_done, 1'b0);
    check({name, "_busy_set"}, load_busy, 1'b1);
    for (lat = 1; lat <= LAT_LIT + 20; lat++) begin
      @(posedge clk) #1;
      if (load_done) begin
        seen = 1'b1;
        break;
      end
      load_start = (poke_busy && lat == 40) || (poke_done && !load_busy);
    end
    load_start = 1'b0;
    check({name, "_latency"}, seen ? lat : 0, LAT_LIT);
    check({name, "_sclk_rises"}, total_rises - r0, N);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) stream[i] = 1'b0;
    pend_info = '0; pend_vld = '0; pend_err = 1'b0;

    // Reset with noise on the serial input.
    #1 rst_n = 1'b0;
    noise_en = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1 noise = 1'($urandom_range(0, 1));
    end
    check("rst_cs_n", nvm_cs_n, 1'b1);
    check("rst_sclk", nvm_sclk, 1'b0);
    check("rst_info", repair_info_nvm, '0);
    check("rst_flags", {load_busy, load_done, load_err}, 3'b000);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("no_sclk_idle", total_rises, 0);
    noise_en = 1'b0;

    // Load 1: ordering, mid-SHIFT start and DONE-cycle start both ignored.
    set_load('{1'b1, 11'h015, 1'b0}, '{1'b0, 11'h7FF, 1'b0}, '{1'b1, 11'h000, 1'b0});
    run_load("ld1", 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("ld1_done_sticky", load_done, 1'b1);
    check("ld1_ch0", repair_info_nvm[0], 11'h015);
    check("ld1_ch1", repair_info_nvm[1], 11'h7FF);
    check("ld1_ch2", repair_info_nvm[2], 11'h000);
    check("ld1_vld", repair_info_vld, 3'b101);

    // Load 2: previous values held until LATCH.
    set_load('{1'b1, 11'h405, 1'b0}, '{1'b1, 11'h2AA, 1'b0}, '{1'b0, 11'h155, 1'b0});
    run_load("ld2", 1'b0, 1'b0);
    #1;
    check("ld2_ch0", repair_info_nvm[0], 11'h405);
    check("ld2_vld", repair_info_vld, 3'b011);

    // Load 3 interrupted by reset during bit 7 of channel 0.
    set_load('{1'b0, 11'h0F0, 1'b0}, '{1'b1, 11'h111, 1'b0}, '{1'b1, 11'h222, 1'b0});
    @(negedge clk) load_start = 1'b1;
    @(posedge clk) #1 load_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk) #1;
      if (rise_cnt == 7 && !nvm_sclk) break;
    end
    check("reach_bit7", rise_cnt, 7);
    check("pre_rst_ch0", {repair_info_vld[0], repair_info_nvm[0]}, {1'b1, 11'h405});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_info", repair_info_nvm, '0);
    check("mid_rst_vld", repair_info_vld, '0);
    check("mid_rst_cs_n", nvm_cs_n, 1'b1);
    check("mid_rst_busy", load_busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Load 4 after reset release completes normally.
    set_load('{1'b1, 11'h3C3, 1'b0}, '{1'b1, 11'h001, 1'b0}, '{1'b1, 11'h7FE, 1'b0});
    run_load("ld4", 1'b0, 1'b0);
    #1;
    check("ld4_ch0", repair_info_nvm[0], 11'h3C3);
    check("ld4_ch2", repair_info_nvm[2], 11'h7FE);
    check("ld4_vld", repair_info_vld, 3'b111);
    check("ld4_err", load_err, 1'b0);

`ifdef ITRX_AIB_REPAIR_PARITY_EN
    // Load 5: channel 0 carries a bad parity bit.
    set_load('{1'b1, 11'h123, 1'b1}, '{1'b1, 11'h003, 1'b0}, '{1'b1, 11'h040, 1'b0});
    run_load("ld5", 1'b0, 1'b0);
    #1;
    check("ld5_ch0", {repair_info_vld[0], repair_info_nvm[0]}, 12'h000);
    check("ld5_ch1", {repair_info_vld[1], repair_info_nvm[1]}, {1'b1, 11'h003});
    check("ld5_err", load_err, 1'b1);
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
